// File: rtl/bbox_detect.sv
// Per-frame bounding-box detector: tracks min/max row and column of dark
// pixels plus their count over one raster frame, and publishes clamped
// {max, min} bounds one cycle after the frame's last pixel.
module bbox_detect #(
  parameter int         ROW_MAX    = 480,
  parameter int         COL_MAX    = 640,
  parameter logic [9:0] THRESH     = 10'd512,
  parameter int         MIN_PIXELS = 16,
  parameter int         MARGIN     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [9:0]  Row,
  input  logic [9:0]  Col,
  input  logic [9:0]  iBW,
  output logic [19:0] oRow,
  output logic [19:0] oCol,
  output logic        oFound,
  output logic        oValid
);

  localparam logic [9:0]  RLAST = 10'(ROW_MAX - 1);
  localparam logic [9:0]  CLAST = 10'(COL_MAX - 1);
  localparam logic [9:0]  RHI   = 10'(ROW_MAX - 1 - MARGIN);
  localparam logic [9:0]  CHI   = 10'(COL_MAX - 1 - MARGIN);
  localparam logic [9:0]  LO    = 10'(MARGIN);
  localparam logic [18:0] MINP  = 19'(MIN_PIXELS);

  typedef enum logic [1:0] {IDLE, SCAN, LATCH} state_t;

  state_t      state, state_nxt;
  logic [9:0]  rmin, rmax, cmin, cmax;
  logic [9:0]  rmin_b, rmax_b, cmin_b, cmax_b;
  logic [9:0]  rmin_n, rmax_n, cmin_n, cmax_n;
  logic [18:0] cnt, cnt_b, cnt_n;
  logic        start, last, in_range, fg, init, take, found;

  // Raise a bound to the lower margin so downstream min-1 cannot wrap.
  function automatic logic [9:0] clamp_lo(input logic [9:0] v);
    return (v < LO) ? LO : v;
  endfunction

  // Pull a bound down to the upper margin so downstream max+4 cannot wrap.
  function automatic logic [9:0] clamp_hi(input logic [9:0] v, input logic [9:0] hi);
    return (v > hi) ? hi : v;
  endfunction

  // Saturating pixel counter increment.
  function automatic logic [18:0] sat_inc(input logic [18:0] c);
    return (&c) ? c : c + 19'd1;
  endfunction

  assign start    = en && (Row == 10'd0) && (Col == 10'd0);
  assign last     = en && (Row == RLAST) && (Col == CLAST);
  assign in_range = ({1'b0, Row} < 11'(ROW_MAX)) && ({1'b0, Col} < 11'(COL_MAX));
  assign fg       = iBW < THRESH;
  // A frame start during LATCH is dropped; elsewhere it (re)initialises.
  assign init     = start && (state != LATCH);
  assign take     = init || ((state == SCAN) && en && in_range);
  assign found    = cnt >= MINP;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic: a restart in SCAN stays in SCAN with fresh accumulators.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (last)  state_nxt = LATCH;
      LATCH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator update: start from initial values on a frame start, then fold in this pixel.
  always_comb begin
    rmin_b = init ? RLAST : rmin;
    rmax_b = init ? 10'd0 : rmax;
    cmin_b = init ? CLAST : cmin;
    cmax_b = init ? 10'd0 : cmax;
    cnt_b  = init ? 19'd0 : cnt;
    rmin_n = rmin_b;
    rmax_n = rmax_b;
    cmin_n = cmin_b;
    cmax_n = cmax_b;
    cnt_n  = cnt_b;
    if (fg) begin
      rmin_n = (Row < rmin_b) ? Row : rmin_b;
      rmax_n = (Row > rmax_b) ? Row : rmax_b;
      cmin_n = (Col < cmin_b) ? Col : cmin_b;
      cmax_n = (Col > cmax_b) ? Col : cmax_b;
      cnt_n  = sat_inc(cnt_b);
    end
  end

  // Accumulator registers, written only on accepted samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rmin <= RLAST;
      rmax <= 10'd0;
      cmin <= CLAST;
      cmax <= 10'd0;
      cnt  <= 19'd0;
    end else if (take) begin
      rmin <= rmin_n;
      rmax <= rmax_n;
      cmin <= cmin_n;
      cmax <= cmax_n;
      cnt  <= cnt_n;
    end
  end

  // Publish: bounds update only for a valid detection; oValid pulses every frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oRow   <= 20'd0;
      oCol   <= 20'd0;
      oFound <= 1'b0;
      oValid <= 1'b0;
    end else begin
      oValid <= (state == LATCH);
      if (state == LATCH) begin
        oFound <= found;
        if (found) begin
          oRow <= {clamp_hi(rmax, RHI), clamp_lo(rmin)};
          oCol <= {clamp_hi(cmax, CHI), clamp_lo(cmin)};
        end
      end
    end
  end

endmodule

// File: tb/tb_bbox_detect.sv
// Self-checking bench for bbox_detect: randomized sparse/gapped frames checked
// cycle by cycle against a queue-based frame model.
module tb_bbox_detect;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [9:0]  Row = '0;
  logic [9:0]  Col = '0;
  logic [9:0]  iBW = '0;
  logic [19:0] oRow, oCol;
  logic        oFound, oValid;

  bbox_detect dut (
    .clk(clk), .rst(rst), .en(en), .Row(Row), .Col(Col), .iBW(iBW),
    .oRow(oRow), .oCol(oCol), .oFound(oFound), .oValid(oValid)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: collects the foreground pixels of the current frame.
  bit          in_frame = 0;
  bit          pend     = 0;
  int          fr[$];
  int          fc[$];
  logic [19:0] m_row = '0, m_col = '0;
  bit          m_found = 0, m_valid = 0;
  int          npulse = 0;

  function automatic void model_publish();
    int rmn, rmx, cmn, cmx;
    rmn = 479; rmx = 0; cmn = 639; cmx = 0;
    if (fr.size() >= 16) begin
      foreach (fr[i]) begin
        if (fr[i] < rmn) rmn = fr[i];
        if (fr[i] > rmx) rmx = fr[i];
        if (fc[i] < cmn) cmn = fc[i];
        if (fc[i] > cmx) cmx = fc[i];
      end
      if (rmn < 4) rmn = 4;
      if (rmx > 475) rmx = 475;
      if (cmn < 4) cmn = 4;
      if (cmx > 635) cmx = 635;
      m_row = {10'(rmx), 10'(rmn)};
      m_col = {10'(cmx), 10'(cmn)};
      m_found = 1;
    end else begin
      m_found = 0;
    end
  endfunction

  function automatic void model_edge(input bit e, input int r, input int c, input int bw);
    if (pend) begin
      model_publish();
      m_valid  = 1;
      pend     = 0;
      in_frame = 0;
    end else begin
      m_valid = 0;
      if (e) begin
        if (r == 0 && c == 0) begin
          in_frame = 1;
          fr.delete();
          fc.delete();
          if (bw < 512) begin fr.push_back(r); fc.push_back(c); end
        end else if (in_frame && r < 480 && c < 640) begin
          if (bw < 512) begin fr.push_back(r); fc.push_back(c); end
          if (r == 479 && c == 639) begin
            pend     = 1;
            in_frame = 0;
          end
        end
      end
    end
  endfunction

  task automatic step(input bit e, input logic [9:0] r, input logic [9:0] c, input logic [9:0] bw);
    en = e; Row = r; Col = c; iBW = bw;
    @(posedge clk);
    #1;
    model_edge(e, int'(r), int'(c), int'(bw));
    chk("oValid", oValid, m_valid);
    chk("oFound", oFound, m_found);
    chk("oRow",   oRow,   m_row);
    chk("oCol",   oCol,   m_col);
    if (oValid) npulse++;
  endtask

  task automatic px(input int r, input int c, input bit f, input int gap);
    logic [9:0] v;
    while ($urandom_range(0, 99) < gap)
      step(1'b0, 10'($urandom), 10'($urandom), 10'($urandom));
    if (f) v = ($urandom_range(0, 3) == 0) ? 10'd511 : 10'($urandom_range(0, 511));
    else   v = ($urandom_range(0, 3) == 0) ? 10'd512 : 10'($urandom_range(512, 1023));
    step(1'b1, 10'(r), 10'(c), v);
  endtask

  task automatic rand_addr(output int r, output int c);
    do begin
      r = $urandom_range(0, 479);
      c = $urandom_range(0, 639);
    end while ((r == 0 && c == 0) || (r == 479 && c == 639));
  endtask

  // Sparse frame: (0,0), optional block, scattered dark/light pixels, (479,639).
  task automatic send_frame(input int r0, input int r1, input int c0, input int c1,
                            input int nfg, input int nbg, input int gap, input bit tail);
    int r, c;
    px(0, 0, (r0 <= 0 && r1 >= 0 && c0 <= 0 && c1 >= 0), gap);
    if (r0 >= 0)
      for (int i = r0; i <= r1; i++)
        for (int j = c0; j <= c1; j++)
          px(i, j, 1'b1, gap);
    repeat (nfg) begin rand_addr(r, c); px(r, c, 1'b1, gap); end
    repeat (nbg) begin
      rand_addr(r, c);
      px(r, c, 1'b0, gap);
      if ($urandom_range(0, 3) == 0)
        step(1'b1, 10'($urandom_range(480, 1023)), 10'($urandom_range(0, 1023)), 10'd0);
    end
    px(479, 639, (r0 <= 479 && r1 >= 479 && c0 <= 639 && c1 >= 639), gap);
    if (tail) repeat (3) step(1'b0, 10'd0, 10'd0, 10'd0);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    #1;
    chk({tag, "_row"},   oRow,   0);
    chk({tag, "_col"},   oCol,   0);
    chk({tag, "_found"}, oFound, 0);
    chk({tag, "_valid"}, oValid, 0);
    in_frame = 0; pend = 0;
    m_row = '0; m_col = '0; m_found = 0; m_valid = 0;
    fr.delete(); fc.delete();
    #2 rst = 1'b1;
  endtask

  initial begin
    int a, b, w, h;
    #3;
    chk("rst_row", oRow, 0);
    chk("rst_col", oCol, 0);
    chk("rst_found", oFound, 0);
    chk("rst_valid", oValid, 0);
    #9 rst = 1'b1;

    // All-light frame
    npulse = 0;
    send_frame(-1, 0, 0, 0, 0, 40, 20, 1'b1);
    chk("white_pulses", npulse, 1);
    chk("white_found", oFound, 0);
    chk("white_row", oRow, 0);

    // Central block, twice
    repeat (2) begin
      send_frame(100, 150, 200, 260, 0, 20, 0, 1'b1);
      chk("blk_row", oRow, (150 << 10) | 100);
      chk("blk_col", oCol, (260 << 10) | 200);
      chk("blk_found", oFound, 1);
    end

    // Too few dark pixels: bounds held
    npulse = 0;
    send_frame(-1, 0, 0, 0, 10, 20, 10, 1'b1);
    chk("few_pulses", npulse, 1);
    chk("few_found", oFound, 0);
    chk("few_row", oRow, (150 << 10) | 100);
    chk("few_col", oCol, (260 << 10) | 200);

    // Corner block clamped by the margin
    send_frame(0, 10, 630, 639, 0, 10, 0, 1'b1);
    chk("corner_row", oRow, (10 << 10) | 4);
    chk("corner_col", oCol, (635 << 10) | 630);
    chk("corner_found", oFound, 1);

    // Mid-frame restart discards the partial frame
    npulse = 0;
    px(0, 0, 1'b0, 0);
    for (int i = 50; i <= 60; i++)
      for (int j = 100; j <= 110; j++) px(i, j, 1'b1, 0);
    send_frame(300, 320, 10, 20, 0, 10, 10, 1'b1);
    chk("restart_pulses", npulse, 1);
    chk("restart_row", oRow, (320 << 10) | 300);
    chk("restart_col", oCol, (20 << 10) | 10);

    // Frame start during LATCH is lost; later dark pixels ignored until a real start
    npulse = 0;
    send_frame(200, 210, 300, 310, 0, 5, 0, 1'b0);
    step(1'b1, 10'd0, 10'd0, 10'd0);
    for (int i = 0; i < 20; i++) px(400, 500 + i, 1'b1, 0);
    px(479, 639, 1'b1, 0);
    repeat (3) step(1'b0, 10'd0, 10'd0, 10'd0);
    chk("lost_pulses", npulse, 1);
    chk("lost_row", oRow, (210 << 10) | 200);

    // Reset mid-SCAN
    px(0, 0, 1'b0, 0);
    for (int j = 0; j < 30; j++) px(70, 100 + j, 1'b1, 0);
    async_reset("rscan");

    // Reset mid-LATCH after a found frame
    send_frame(100, 120, 100, 120, 0, 5, 0, 1'b1);
    send_frame(130, 140, 130, 140, 0, 5, 0, 1'b0);
    async_reset("rlatch");

    // Heavily gapped frame after reset
    npulse = 0;
    send_frame(40, 60, 500, 520, 0, 30, 40, 1'b1);
    chk("gap_pulses", npulse, 1);
    chk("gap_row", oRow, (60 << 10) | 40);
    chk("gap_col", oCol, (520 << 10) | 500);

    // Random rectangles and noise
    repeat (6) begin
      h = $urandom_range(0, 20);
      w = $urandom_range(0, 20);
      a = $urandom_range(0, 479 - h);
      b = $urandom_range(0, 639 - w);
      send_frame(a, a + h, b, b + w, $urandom_range(0, 20), $urandom_range(0, 40),
                 $urandom_range(0, 50), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
